// File: rtl/quickint_controller_pkg.sv
// Shared definitions for the quick-interrupt controller.
// Register encodings, control-bit positions and bus FSM states.
package quickint_controller_pkg;

    localparam logic [7:0] DEFAULT_VECTOR = 8'd24;

    localparam logic REG_VEC  = 1'b0;
    localparam logic REG_CTRL = 1'b1;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_EDGE = 1;
    localparam int CTRL_CLR  = 2;
    localparam int CTRL_PEND = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POLL,
        ST_ACK,
        ST_VEC_DONE,
        ST_REG_RD,
        ST_REG_WR
    } bus_state_t;

    function automatic logic [7:0] ctrl_word(
        input logic en,
        input logic edge_mode,
        input logic pend
    );
        logic [7:0] w;
        w            = '0;
        w[CTRL_EN]   = en;
        w[CTRL_EDGE] = edge_mode;
        w[CTRL_PEND] = pend;
        return w;
    endfunction

endpackage

// File: rtl/quickint_controller_channel.sv
// One interrupt channel: synchroniser, bus-frozen level and pending logic.
// Holds the vector and control bits written by the host.
module quickint_channel
    import quickint_controller_pkg::*;
#(
    parameter logic [7:0] DEFAULTVECTOR = DEFAULT_VECTOR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sint_n,
    input  logic       fcs_n,
    input  logic       wr_vec,
    input  logic       wr_ctrl,
    input  logic       ack,
    input  logic [7:0] din,
    output logic [7:0] vec,
    output logic       en,
    output logic       edge_mode,
    output logic       pend,
    output logic       raw
);

    logic [1:0] sync;
    logic       held;
    logic       pend_edge;
    logic       set_edge;
    logic       clr_edge;

    assign raw      = sync[1];
    assign set_edge = edge_mode & fcs_n & raw & ~held;
    assign clr_edge = ack | (wr_ctrl & din[CTRL_CLR]);
    assign pend     = edge_mode ? pend_edge : held;

    // Synchronise the request, freeze it during bus cycles, track edges and host writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync      <= '0;
            held      <= 1'b0;
            pend_edge <= 1'b0;
            vec       <= DEFAULTVECTOR;
            en        <= 1'b0;
            edge_mode <= 1'b0;
        end else begin
            sync <= {sync[0], ~sint_n};
            if (fcs_n) begin
                held <= raw;
            end
            if (set_edge) begin
                pend_edge <= 1'b1;
            end else if (clr_edge) begin
                pend_edge <= 1'b0;
            end
            if (wr_vec) begin
                vec <= din;
            end
            if (wr_ctrl) begin
                en        <= din[CTRL_EN];
                edge_mode <= din[CTRL_EDGE];
            end
        end
    end

endmodule

// File: rtl/quickint_controller.sv
// Zorro III quick-interrupt controller: arbiter, register port and bus FSM.
// Channels are answered with their vector during the quick-interrupt cycle.
module quickint_controller
    import quickint_controller_pkg::*;
#(
    parameter int         NCH           = 2,
    parameter logic [7:0] DEFAULTVECTOR = DEFAULT_VECTOR,
    localparam int        CW            = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           IORST,
    input  logic [NCH-1:0] SINT_n,
    input  logic           intreg_cycle,
    input  logic           quickint_cycle,
    input  logic           FCS_n,
    input  logic           DOE,
    input  logic           DS0_n,
    input  logic           READ,
    input  logic           SLAVE_n,
    input  logic [CW-1:0]  ch_sel,
    input  logic           reg_sel,
    input  logic [7:0]     din,
    output logic [7:0]     dout,
    output logic           int_sig,
    output logic           dtack,
    output logic           slave,
    output logic           vector_read,
    output logic [NCH-1:0] ack_ch
);

    logic [7:0]     vec_all [NCH];
    logic [NCH-1:0] en;
    logic [NCH-1:0] edge_mode;
    logic [NCH-1:0] pend;
    logic [NCH-1:0] raw;
    logic [NCH-1:0] wr_vec;
    logic [NCH-1:0] wr_ctrl;

    bus_state_t     state;
    bus_state_t     state_next;
    logic [CW-1:0]  win_q;
    logic [CW-1:0]  winner;
    logic           any;
    logic           qc;
    logic           reg_wr_c;
    logic           reg_rd_c;
    logic           poll_c;
    logic           vec_c;
    logic           wr_fire;
    logic           ld_win;
    logic [7:0]     rd_data;
    logic [7:0]     vec_win;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        quickint_channel #(
            .DEFAULTVECTOR(DEFAULTVECTOR)
        ) u_ch (
            .clk      (clk),
            .rst      (IORST),
            .sint_n   (SINT_n[i]),
            .fcs_n    (FCS_n),
            .wr_vec   (wr_vec[i]),
            .wr_ctrl  (wr_ctrl[i]),
            .ack      (ack_ch[i]),
            .din      (din),
            .vec      (vec_all[i]),
            .en       (en[i]),
            .edge_mode(edge_mode[i]),
            .pend     (pend[i]),
            .raw      (raw[i])
        );
    end

    assign qc       = quickint_cycle & any;
    assign reg_wr_c = !FCS_n & intreg_cycle & DOE & !READ & !DS0_n;
    assign reg_rd_c = !FCS_n & intreg_cycle & DOE & READ;
    assign poll_c   = !FCS_n & qc & !DOE & DS0_n;
    assign vec_c    = !FCS_n & qc & slave & DOE & !DS0_n & !SLAVE_n;

    // Lowest enabled pending channel wins; unenabled channels still raise int_sig from raw level.
    always_comb begin
        any     = 1'b0;
        winner  = '0;
        int_sig = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (en[i] & pend[i]) begin
                any    = 1'b1;
                winner = CW'(i);
            end
            int_sig = int_sig | (en[i] ? pend[i] : raw[i]);
        end
    end

    // Channel select decode for register access and winner vector mux.
    always_comb begin
        wr_vec  = '0;
        wr_ctrl = '0;
        rd_data = 8'h00;
        vec_win = DEFAULTVECTOR;
        for (int i = 0; i < NCH; i++) begin
            if (ch_sel == CW'(i)) begin
                wr_vec[i]  = wr_fire & (reg_sel == REG_VEC);
                wr_ctrl[i] = wr_fire & (reg_sel == REG_CTRL);
                rd_data    = (reg_sel == REG_CTRL)
                           ? ctrl_word(en[i], edge_mode[i], pend[i])
                           : vec_all[i];
            end
            if (win_q == CW'(i)) begin
                vec_win = vec_all[i];
            end
        end
    end

    // Bus FSM next state: register access beats poll, poll beats vector phase.
    always_comb begin
        state_next = state;
        wr_fire    = 1'b0;
        ld_win     = 1'b0;
        if (FCS_n) begin
            state_next = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE, ST_POLL: begin
                    if (reg_wr_c | reg_rd_c) begin
                        state_next = reg_rd_c ? ST_REG_RD : ST_REG_WR;
                        wr_fire    = reg_wr_c;
                    end else if (state == ST_IDLE && poll_c) begin
                        state_next = ST_POLL;
                        ld_win     = 1'b1;
                    end else if (state == ST_POLL && vec_c) begin
                        state_next = ST_ACK;
                    end
                end
                ST_ACK: state_next = ST_VEC_DONE;
                default: ;
            endcase
        end
    end

    // Bus strobes follow the state; the acknowledge pulse lasts only the ACK state.
    always_comb begin
        slave       = state inside {ST_POLL, ST_ACK, ST_VEC_DONE};
        vector_read = state inside {ST_ACK, ST_VEC_DONE, ST_REG_RD};
        dtack       = state inside {ST_VEC_DONE, ST_REG_RD, ST_REG_WR};
        ack_ch      = '0;
        for (int i = 0; i < NCH; i++) begin
            ack_ch[i] = (state == ST_ACK) && (win_q == CW'(i));
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (IORST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Winner latch at poll and data bus register loaded on read or vector delivery.
    always_ff @(posedge clk) begin
        if (IORST) begin
            win_q <= '0;
            dout  <= DEFAULTVECTOR;
        end else begin
            if (ld_win) begin
                win_q <= winner;
            end
            if (FCS_n) begin
                dout <= DEFAULTVECTOR;
            end else if (state_next == ST_REG_RD && state != ST_REG_RD) begin
                dout <= rd_data;
            end else if (state_next == ST_ACK) begin
                dout <= vec_win;
            end
        end
    end

endmodule

// File: tb/tb_quickint_controller.sv
// Directed bench for quickint_controller (2-channel unit plus 3-channel
// unit for out-of-range channel selects).
module tb_quickint_controller;

    logic       clk = 1'b0;
    logic       IORST;
    logic [1:0] SINT_n;
    logic       intreg_cycle;
    logic       quickint_cycle;
    logic       FCS_n;
    logic       DOE;
    logic       DS0_n;
    logic       READ;
    logic       SLAVE_n;
    logic [0:0] ch_sel;
    logic       reg_sel;
    logic [7:0] din;
    logic [7:0] dout;
    logic       int_sig;
    logic       dtack;
    logic       slave;
    logic       vector_read;
    logic [1:0] ack_ch;

    logic [2:0] SINT3_n;
    logic       intreg3;
    logic [1:0] ch_sel3;
    logic [7:0] dout3;
    logic       int3;
    logic       dtack3;
    logic       slave3;
    logic       vr3;
    logic [2:0] ack3;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    quickint_controller dut (
        .clk           (clk),
        .IORST         (IORST),
        .SINT_n        (SINT_n),
        .intreg_cycle  (intreg_cycle),
        .quickint_cycle(quickint_cycle),
        .FCS_n         (FCS_n),
        .DOE           (DOE),
        .DS0_n         (DS0_n),
        .READ          (READ),
        .SLAVE_n       (SLAVE_n),
        .ch_sel        (ch_sel),
        .reg_sel       (reg_sel),
        .din           (din),
        .dout          (dout),
        .int_sig       (int_sig),
        .dtack         (dtack),
        .slave         (slave),
        .vector_read   (vector_read),
        .ack_ch        (ack_ch)
    );

    quickint_controller #(.NCH(3)) dut3 (
        .clk           (clk),
        .IORST         (IORST),
        .SINT_n        (SINT3_n),
        .intreg_cycle  (intreg3),
        .quickint_cycle(quickint_cycle),
        .FCS_n         (FCS_n),
        .DOE           (DOE),
        .DS0_n         (DS0_n),
        .READ          (READ),
        .SLAVE_n       (SLAVE_n),
        .ch_sel        (ch_sel3),
        .reg_sel       (reg_sel),
        .din           (din),
        .dout          (dout3),
        .int_sig       (int3),
        .dtack         (dtack3),
        .slave         (slave3),
        .vector_read   (vr3),
        .ack_ch        (ack3)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle;
        FCS_n          = 1'b1;
        intreg_cycle   = 1'b0;
        intreg3        = 1'b0;
        quickint_cycle = 1'b0;
        DOE            = 1'b0;
        DS0_n          = 1'b1;
        READ           = 1'b0;
        SLAVE_n        = 1'b1;
    endtask

    task automatic reg_wr(input bit u3, input logic [1:0] ch, input logic rs,
                          input logic [7:0] d, input string tag);
        FCS_n        = 1'b0;
        intreg_cycle = !u3;
        intreg3      = u3;
        DOE          = 1'b1;
        READ         = 1'b0;
        DS0_n        = 1'b0;
        reg_sel      = rs;
        din          = d;
        if (u3) ch_sel3 = ch;
        else    ch_sel  = ch[0];
        tick;
        chk({tag, "_dtack"}, 8'(u3 ? dtack3 : dtack), 8'h01);
        bus_idle;
        tick;
    endtask

    task automatic reg_rd(input bit u3, input logic [1:0] ch, input logic rs,
                          input logic [7:0] want, input string tag);
        FCS_n        = 1'b0;
        intreg_cycle = !u3;
        intreg3      = u3;
        DOE          = 1'b1;
        READ         = 1'b1;
        DS0_n        = 1'b0;
        reg_sel      = rs;
        if (u3) ch_sel3 = ch;
        else    ch_sel  = ch[0];
        tick;
        for (int n = 1; n < 2 && !(u3 ? dtack3 : dtack); n++) tick;
        chk({tag, "_dtack"}, 8'(u3 ? dtack3 : dtack), 8'h01);
        chk({tag, "_vr"}, 8'(u3 ? vr3 : vector_read), 8'h01);
        chk(tag, u3 ? dout3 : dout, want);
        bus_idle;
        tick;
    endtask

    task automatic quick(input logic [7:0] want_dout, input logic [1:0] want_ack,
                         input logic want_slave, input string tag);
        FCS_n          = 1'b0;
        quickint_cycle = 1'b1;
        DOE            = 1'b0;
        DS0_n          = 1'b1;
        SLAVE_n        = 1'b1;
        tick;
        chk({tag, "_slave"}, 8'(slave), 8'(want_slave));
        DOE     = 1'b1;
        DS0_n   = 1'b0;
        SLAVE_n = 1'b0;
        tick;
        chk({tag, "_vec"}, dout, want_dout);
        chk({tag, "_ack"}, 8'(ack_ch), 8'(want_ack));
        chk({tag, "_vr"}, 8'(vector_read), 8'(want_slave));
        tick;
        chk({tag, "_dtack"}, 8'(dtack), 8'(want_slave));
        chk({tag, "_ackoff"}, 8'(ack_ch), 8'h00);
        bus_idle;
        tick;
        chk({tag, "_idle"}, 8'({dtack, slave, vector_read}), 8'h00);
    endtask

    task automatic pulse0;
        SINT_n[0] = 1'b0;
        repeat (3) tick;
        SINT_n[0] = 1'b1;
        repeat (4) tick;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        bus_idle;
        SINT_n  = 2'b11;
        SINT3_n = 3'b111;
        ch_sel  = 1'b0;
        ch_sel3 = 2'd0;
        reg_sel = 1'b0;
        din     = 8'h00;
        IORST   = 1'b1;
        tick;
        tick;
        IORST = 1'b0;
        chk("rst_dout", dout, 8'd24);
        chk("rst_bus", 8'({dtack, slave, vector_read}), 8'h00);
        chk("rst_ack", 8'(ack_ch), 8'h00);
        chk("rst_int", 8'(int_sig), 8'h00);

        reg_rd(0, 2'd0, 1'b0, 8'd24, "rd_vec0");
        reg_rd(0, 2'd1, 1'b0, 8'd24, "rd_vec1");
        reg_rd(0, 2'd0, 1'b1, 8'h00, "rd_ctl0");

        reg_wr(1, 2'd3, 1'b0, 8'h55, "w3_oob");
        reg_rd(1, 2'd3, 1'b0, 8'h00, "r3_oob");
        reg_rd(1, 2'd3, 1'b1, 8'h00, "r3_oobc");
        reg_rd(1, 2'd2, 1'b0, 8'd24, "r3_ch2");
        reg_rd(1, 2'd0, 1'b0, 8'd24, "r3_ch0");
        reg_wr(1, 2'd2, 1'b0, 8'h66, "w3_ch2");
        reg_rd(1, 2'd2, 1'b0, 8'h66, "r3_ch2b");

        reg_wr(0, 2'd1, 1'b0, 8'h40, "w_vec1");
        reg_wr(0, 2'd1, 1'b1, 8'h01, "w_ctl1");
        SINT_n = 2'b01;
        repeat (4) tick;
        chk("int_lvl1", 8'(int_sig), 8'h01);
        quick(8'h40, 2'b10, 1'b1, "q_ch1");

        reg_wr(0, 2'd0, 1'b0, 8'h30, "w_vec0");
        reg_wr(0, 2'd0, 1'b1, 8'h01, "w_ctl0");
        SINT_n = 2'b00;
        repeat (4) tick;
        quick(8'h30, 2'b01, 1'b1, "q_prio");
        reg_rd(0, 2'd0, 1'b1, 8'h05, "rd_ctl0_lvl");

        reg_wr(0, 2'd0, 1'b1, 8'h00, "w_dis0");
        reg_wr(0, 2'd1, 1'b1, 8'h00, "w_dis1");
        SINT_n = 2'b10;
        repeat (4) tick;
        chk("int_raw", 8'(int_sig), 8'h01);
        quick(8'd24, 2'b00, 1'b0, "q_none");

        SINT_n = 2'b11;
        repeat (4) tick;
        chk("int_quiet", 8'(int_sig), 8'h00);
        reg_wr(0, 2'd0, 1'b1, 8'h03, "w_edge0");
        reg_rd(0, 2'd0, 1'b1, 8'h03, "rd_edge0");
        pulse0;
        reg_rd(0, 2'd0, 1'b1, 8'h07, "rd_pend0");
        chk("int_edge", 8'(int_sig), 8'h01);
        quick(8'h30, 2'b01, 1'b1, "q_edge");
        reg_rd(0, 2'd0, 1'b1, 8'h03, "rd_pend0_ack");
        chk("int_edge_off", 8'(int_sig), 8'h00);
        pulse0;
        reg_rd(0, 2'd0, 1'b1, 8'h07, "rd_pend0_b");
        reg_wr(0, 2'd0, 1'b1, 8'h07, "w_clr0");
        reg_rd(0, 2'd0, 1'b1, 8'h03, "rd_clr0");

        reg_wr(0, 2'd0, 1'b1, 8'h00, "w_off0");
        reg_wr(0, 2'd1, 1'b1, 8'h01, "w_en1");
        SINT_n = 2'b01;
        repeat (4) tick;
        FCS_n          = 1'b0;
        quickint_cycle = 1'b1;
        DOE            = 1'b0;
        DS0_n          = 1'b1;
        SLAVE_n        = 1'b1;
        tick;
        chk("frz_slave", 8'(slave), 8'h01);
        SINT_n = 2'b11;
        repeat (4) tick;
        chk("frz_hold", 8'(slave), 8'h01);
        chk("frz_int", 8'(int_sig), 8'h01);
        DOE     = 1'b1;
        DS0_n   = 1'b0;
        SLAVE_n = 1'b0;
        tick;
        chk("frz_vec", dout, 8'h40);
        chk("frz_ack", 8'(ack_ch), 8'h02);
        tick;
        chk("frz_dtack", 8'(dtack), 8'h01);
        bus_idle;
        repeat (5) tick;
        chk("frz_rel_int", 8'(int_sig), 8'h00);

        SINT_n = 2'b01;
        repeat (4) tick;
        FCS_n          = 1'b0;
        quickint_cycle = 1'b1;
        DOE            = 1'b0;
        DS0_n          = 1'b1;
        SLAVE_n        = 1'b1;
        tick;
        chk("ab_poll", 8'(slave), 8'h01);
        DOE     = 1'b1;
        DS0_n   = 1'b0;
        SLAVE_n = 1'b0;
        IORST   = 1'b1;
        SINT_n  = 2'b11;
        tick;
        chk("ab_slave", 8'(slave), 8'h00);
        chk("ab_ack", 8'(ack_ch), 8'h00);
        chk("ab_vr", 8'(vector_read), 8'h00);
        chk("ab_dout", dout, 8'd24);
        IORST = 1'b0;
        bus_idle;
        tick;
        chk("ab_ack2", 8'(ack_ch), 8'h00);
        reg_rd(0, 2'd1, 1'b0, 8'd24, "ab_vec1");
        reg_rd(0, 2'd0, 1'b0, 8'd24, "ab_vec0");
        reg_rd(0, 2'd1, 1'b1, 8'h00, "ab_ctl1");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
